// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared types, constants and duty arithmetic for the RGB PWM
// sequencer and its per-channel slices.
//   mode_e      : STATIC / BLINK / BREATHE / RSVD (RSVD behaves as STATIC)
//   chan_e      : RED / GREEN / BLUE / ALL write targets
//   blink_e     : ON/OFF state of the blink FSM
//   dir_e       : UP/DOWN state of the breathe FSM
//   scale_duty  : min((duty * (scale + 1)) >> 8, max_duty), forced 0 at scale 0
//   gamma_duty  : (duty * (duty + 1)) >> 8, used only when RGB_PWM_GAMMA_EN is set
package rgb_pwm_pkg;

    typedef logic [7:0] duty_t;
    typedef logic [7:0] scale_t;

    typedef enum logic [1:0] {STATIC = 2'd0, BLINK = 2'd1, BREATHE = 2'd2, RSVD = 2'd3} mode_e;
    typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, ALL = 2'd3} chan_e;
    typedef enum logic {BLK_ON = 1'b0, BLK_OFF = 1'b1} blink_e;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    // Last pwm_cnt value of a period; a duty of 255 therefore never goes low.
    localparam duty_t  PWM_MAX    = 8'd254;
    localparam scale_t SCALE_FULL = 8'd255;

    function automatic duty_t scale_duty(input duty_t duty, input scale_t scale,
                                         input duty_t max_duty);
        logic [15:0] prod;
        duty_t       d;
        // 255 * 256 = 65280 still fits in 16 bits, so no overflow bit needed.
        prod = 16'(duty) * (16'(scale) + 16'd1);
        d    = prod[15:8];
        if (scale == '0)
            d = '0;
        else if (d > max_duty)
            d = max_duty;
        return d;
    endfunction

    function automatic duty_t gamma_duty(input duty_t duty);
        logic [15:0] prod;
        prod = 16'(duty) * (16'(duty) + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// rgb_pwm_chan: one colour slice. Holds the active duty, recomputes the
// effective duty only at a period boundary (so a pulse is never split) and
// drives the registered PWM compare.
// Optional feature macro RGB_PWM_GAMMA_EN: gamma-correct the duty before scaling.
// Ports:
//   clk_48m, reset : clock, synchronous active-high reset
//   enable         : 0 forces pwm low on the next cycle
//   boundary       : period_start strobe from the timebase
//   wr, wr_duty    : copy the staged duty into this channel at this boundary
//   scale_nxt      : mode scale that applies to the period about to start
//   pwm_cnt        : shared period counter
//   pwm            : registered PWM enable
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter duty_t MAX_DUTY = 8'd64
) (
    input  logic       clk_48m,
    input  logic       reset,
    input  logic       enable,
    input  logic       boundary,
    input  logic       wr,
    input  duty_t      wr_duty,
    input  scale_t     scale_nxt,
    input  logic [7:0] pwm_cnt,
    output logic       pwm
);

    duty_t duty_q, duty_nxt, duty_src, d_eff;

    // The incoming duty bypasses duty_q so a write takes effect in the very
    // period that its boundary opens.
    always_comb begin
        duty_nxt = wr ? wr_duty : duty_q;
`ifdef RGB_PWM_GAMMA_EN
        duty_src = gamma_duty(duty_nxt);
`else
        duty_src = duty_nxt;
`endif
    end

    always_ff @(posedge clk_48m) begin
        if (reset) begin
            duty_q <= '0;
            d_eff  <= '0;
            pwm    <= 1'b0;
        end else begin
            if (boundary) begin
                duty_q <= duty_nxt;
                d_eff  <= scale_duty(duty_src, scale_nxt, MAX_DUTY);
            end
            pwm <= enable && (pwm_cnt < d_eff);
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: three-channel PWM generator feeding the RGB current-sink
// RGB0PWM/RGB1PWM/RGB2PWM inputs. Provides a prescaled 255-tick period,
// a single-slot duty write handshake applied at period boundaries, and
// STATIC / BLINK / BREATHE brightness modes.
// Optional feature macro RGB_PWM_GAMMA_EN (handled inside rgb_pwm_chan).
// Ports:
//   clk_48m, reset        : 48 MHz clock, synchronous active-high reset
//   enable                : 0 = outputs low, timebase and mode FSMs held reset
//   mode                  : 0 STATIC, 1 BLINK, 2 BREATHE, 3 as STATIC
//   cfg_valid/cfg_ready   : duty write handshake
//   cfg_chan, cfg_duty    : write target (0 R, 1 G, 2 B, 3 all) and duty
//   pwm_red/green/blue    : PWM enables
//   period_start          : one-cycle pulse in the cycle pwm_cnt wraps 254->0
module rgb_pwm_sequencer
    import rgb_pwm_pkg::*;
#(
    parameter int    PRESCALE      = 188,
    parameter duty_t MAX_DUTY      = 8'd64,
    parameter int    BLINK_PERIODS = 250,
    parameter int    BREATHE_DIV   = 2
) (
    input  logic       clk_48m,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_chan,
    input  logic [7:0] cfg_duty,
    output logic       pwm_red,
    output logic       pwm_green,
    output logic       pwm_blue,
    output logic       period_start
);

    localparam int PW = (PRESCALE > 1)      ? $clog2(PRESCALE)      : 1;
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam int DW = (BREATHE_DIV > 1)   ? $clog2(BREATHE_DIV)   : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_PERIODS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BREATHE_DIV - 1);

    // ---------------- timebase ----------------
    logic [PW-1:0] presc;
    logic [7:0]    pwm_cnt;
    logic          tick, boundary;

    assign tick         = (presc == PRE_LAST);
    assign boundary     = enable && tick && (pwm_cnt == PWM_MAX);
    assign period_start = boundary;

    always_ff @(posedge clk_48m) begin
        if (reset || !enable) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= (pwm_cnt == PWM_MAX) ? 8'd0 : pwm_cnt + 8'd1;
        end else begin
            presc   <= presc + PW'(1);
        end
    end

    // ---------------- write staging ----------------
    logic  pending;
    chan_e stage_chan;
    duty_t stage_duty;
    logic [2:0] chan_wr;

    assign cfg_ready = !pending;

    // Staging survives enable=0; only reset discards it.
    always_ff @(posedge clk_48m) begin
        if (reset) begin
            pending    <= 1'b0;
            stage_chan <= RED;
            stage_duty <= '0;
        end else if (cfg_valid && !pending) begin
            pending    <= 1'b1;
            stage_chan <= chan_e'(cfg_chan);
            stage_duty <= cfg_duty;
        end else if (boundary) begin
            pending    <= 1'b0;
        end
    end

    always_comb begin
        chan_wr = '0;
        for (int i = 0; i < 3; i++)
            chan_wr[i] = boundary && pending &&
                         (stage_chan == ALL || stage_chan == chan_e'(2'(i)));
    end

    // ---------------- mode FSMs ----------------
    mode_e            mode_in, mode_q;
    blink_e           blk_q, blk_d;
    dir_e             dir_q, dir_d;
    logic [BW-1:0]    blk_cnt_q, blk_cnt_d;
    logic [DW-1:0]    div_q, div_d;
    scale_t           br_q, br_d, scale_nxt;

    always_ff @(posedge clk_48m) begin
        if (reset || !enable) begin
            mode_q    <= STATIC;
            blk_q     <= BLK_ON;
            blk_cnt_q <= '0;
            dir_q     <= DIR_UP;
            div_q     <= '0;
            br_q      <= '0;
        end else if (boundary) begin
            mode_q    <= mode_in;
            blk_q     <= blk_d;
            blk_cnt_q <= blk_cnt_d;
            dir_q     <= dir_d;
            div_q     <= div_d;
            br_q      <= br_d;
        end
    end

    // Next state is what the coming period uses; it is only committed at the
    // boundary, so mode is effectively sampled on period_start.
    always_comb begin
        mode_in   = (mode_e'(mode) == RSVD) ? STATIC : mode_e'(mode);
        blk_d     = blk_q;
        blk_cnt_d = blk_cnt_q;
        dir_d     = dir_q;
        div_d     = div_q;
        br_d      = br_q;
        scale_nxt = SCALE_FULL;
        case (mode_in)
            BLINK: begin
                if (mode_q != BLINK) begin
                    blk_d     = BLK_ON;
                    blk_cnt_d = '0;
                end else if (blk_cnt_q == BLK_LAST) begin
                    blk_cnt_d = '0;
                    blk_d     = (blk_q == BLK_ON) ? BLK_OFF : BLK_ON;
                end else begin
                    blk_cnt_d = blk_cnt_q + BW'(1);
                end
                scale_nxt = (blk_d == BLK_ON) ? SCALE_FULL : '0;
            end
            BREATHE: begin
                if (mode_q != BREATHE) begin
                    br_d  = '0;
                    dir_d = DIR_UP;
                    div_d = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    // A reversal step moves the other way at once, so each
                    // end point is held for exactly one step.
                    if (dir_q == DIR_UP) begin
                        if (br_q == 8'hFF) begin
                            dir_d = DIR_DOWN;
                            br_d  = br_q - 8'd1;
                        end else begin
                            br_d  = br_q + 8'd1;
                        end
                    end else begin
                        if (br_q == 8'h00) begin
                            dir_d = DIR_UP;
                            br_d  = br_q + 8'd1;
                        end else begin
                            br_d  = br_q - 8'd1;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
                scale_nxt = br_d;
            end
            default: ;
        endcase
    end

    // ---------------- channels ----------------
    logic [2:0] pwm_vec;

    rgb_pwm_chan #(.MAX_DUTY(MAX_DUTY)) u_chan [2:0] (
        .clk_48m   (clk_48m),
        .reset     (reset),
        .enable    (enable),
        .boundary  (boundary),
        .wr        (chan_wr),
        .wr_duty   (stage_duty),
        .scale_nxt (scale_nxt),
        .pwm_cnt   (pwm_cnt),
        .pwm       (pwm_vec)
    );

    assign pwm_red   = pwm_vec[0];
    assign pwm_green = pwm_vec[1];
    assign pwm_blue  = pwm_vec[2];

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer. Two instances share all inputs:
// dut_a keeps the eye-safety ceiling at 64, dut_b opens it to 255. PRESCALE=1
// so one tick is one clock; a monitor totals high cycles per PWM period.
module tb_rgb_pwm_sequencer;

    logic       clk_48m = 1'b0;
    logic       reset = 1'b1, enable = 1'b1, cfg_valid = 1'b0;
    logic [1:0] mode = 2'd0, cfg_chan = 2'd0;
    logic [7:0] cfg_duty = 8'd0;
    logic       cfg_ready_a, cfg_ready_b, period_start_a, period_start_b;
    logic       red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic [2:0] pwm_a, pwm_b;

    int n_vec = 0, n_err = 0;
    int base;
    int nper = 0;
    int run_a[3], run_b[3], last_a[3], last_b[3];
    logic [2:0] ps_sh = 3'b000;

    assign pwm_a = {blue_a, green_a, red_a};
    assign pwm_b = {blue_b, green_b, red_b};

    rgb_pwm_sequencer #(.PRESCALE(1), .MAX_DUTY(8'd64), .BLINK_PERIODS(2), .BREATHE_DIV(1)) u_dut_a (
        .clk_48m(clk_48m), .reset(reset), .enable(enable), .mode(mode),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a), .cfg_chan(cfg_chan), .cfg_duty(cfg_duty),
        .pwm_red(red_a), .pwm_green(green_a), .pwm_blue(blue_a), .period_start(period_start_a));

    rgb_pwm_sequencer #(.PRESCALE(1), .MAX_DUTY(8'd255), .BLINK_PERIODS(2), .BREATHE_DIV(1)) u_dut_b (
        .clk_48m(clk_48m), .reset(reset), .enable(enable), .mode(mode),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b), .cfg_chan(cfg_chan), .cfg_duty(cfg_duty),
        .pwm_red(red_b), .pwm_green(green_b), .pwm_blue(blue_b), .period_start(period_start_b));

    initial forever #5 clk_48m = ~clk_48m;

    // Output lags pwm_cnt by one cycle, so a period's pulses occupy the 255
    // samples starting two samples after its opening period_start.
    initial forever begin
        @(negedge clk_48m);
        ps_sh = {ps_sh[1:0], period_start_a};
        for (int c = 0; c < 3; c++) begin
            if (ps_sh[2]) begin
                last_a[c] = run_a[c];
                last_b[c] = run_b[c];
                run_a[c]  = int'(pwm_a[c]);
                run_b[c]  = int'(pwm_b[c]);
            end else begin
                run_a[c] += int'(pwm_a[c]);
                run_b[c] += int'(pwm_b[c]);
            end
        end
        if (ps_sh[2]) nper++;
    end

    task automatic chk(input string tag, input int got, input int exp_v);
        n_vec++;
        if (got != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_48m);
        #1;
    endtask

    task automatic sync_ps();
        int n = 0;
        do begin step(); n++; end while (!period_start_a && n < 1200);
        chk("ps_seen", int'(period_start_a), 1);
    endtask

    task automatic wait_nper(input int target);
        int n = 0;
        while (nper < target && n < 1200) begin step(); n++; end
        chk("period_seen", int'(nper >= target), 1);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] d);
        int n = 0;
        while (!cfg_ready_a && n < 1200) begin step(); n++; end
        chk("wr_ready", int'(cfg_ready_a), 1);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_duty  = d;
        step();
        cfg_valid = 1'b0;
    endtask

    function automatic int clamp(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Expected high ticks for duty 255 at a given breathe scale.
    function automatic int br_exp(input int s);
        return (s == 0) ? 0 : ((255 * (s + 1)) >> 8);
    endfunction

    int t2_val[3]   = '{200, 0, 255};
    int blink_on[8] = '{1, 1, 0, 0, 1, 1, 0, 1};

    initial begin
        // ---- reset state ----
        repeat (3) step();
        chk("rst_pwm_a", int'(pwm_a), 0);
        chk("rst_pwm_b", int'(pwm_b), 0);
        chk("rst_ps", int'(period_start_a | period_start_b), 0);
        chk("rst_ready", int'(cfg_ready_a & cfg_ready_b), 1);
        reset = 1'b0;

        // ---- 1: static red = 32 ----
        cfg_write(2'd0, 8'd32);
        chk("t1_ready_low", int'(cfg_ready_a), 0);
        sync_ps();
        chk("t1_ready_at_ps", int'(cfg_ready_a), 0);
        base = nper;
        step();
        chk("t1_ready_back", int'(cfg_ready_a), 1);
        wait_nper(base + 2);
        chk("t1_red_a", last_a[0], 32);
        chk("t1_green_a", last_a[1], 0);
        chk("t1_blue_a", last_a[2], 0);
        chk("t1_red_b", last_b[0], 32);

        // ---- 2: ALL = 200 / 0 / 255, clamp and constant levels ----
        for (int i = 0; i < 3; i++) begin
            cfg_write(2'd3, 8'(t2_val[i]));
            sync_ps();
            base = nper;
            wait_nper(base + 2);
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("t2_a_v%0d_c%0d", t2_val[i], c), last_a[c], clamp(t2_val[i], 64));
                chk($sformatf("t2_b_v%0d_c%0d", t2_val[i], c), last_b[c], t2_val[i]);
            end
        end
        wait_nper(base + 3);
        for (int c = 0; c < 3; c++)
            chk($sformatf("t2_b_full_again_c%0d", c), last_b[c], 255);

        // ---- 3: held cfg_valid, green 10 then 20 ----
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_duty  = 8'd10;
        step();
        cfg_duty  = 8'd20;
        chk("t3_busy", int'(cfg_ready_a), 0);
        sync_ps();
        chk("t3_busy_at_ps", int'(cfg_ready_a), 0);
        base = nper;
        step();
        chk("t3_ready_back", int'(cfg_ready_a), 1);
        step();
        cfg_valid = 1'b0;
        chk("t3_second_taken", int'(cfg_ready_a), 0);
        wait_nper(base + 2);
        chk("t3_green_n1", last_b[1], 10);
        chk("t3_red_n1", last_b[0], 255);
        wait_nper(base + 3);
        chk("t3_green_n2", last_b[1], 20);
        chk("t3_green_n2_a", last_a[1], 20);

        // ---- 4: blink, 2 periods on / 2 off, late mode change ----
        cfg_write(2'd3, 8'd255);
        mode = 2'd1;
        sync_ps();
        base = nper;
        for (int p = 0; p < 8; p++) begin
            wait_nper(base + 2 + p);
            chk($sformatf("t4_b_p%0d", p), last_b[0], blink_on[p] ? 255 : 0);
            chk($sformatf("t4_a_p%0d", p), last_a[0], blink_on[p] ? 64 : 0);
            // Inside the OFF period p=6: switching to STATIC shows up at p=7.
            if (p == 5) mode = 2'd0;
        end

        // ---- 5: breathe ramp through the peak ----
        mode = 2'd2;
        sync_ps();
        base = nper;
        for (int j = 0; j < 258; j++) begin
            int s;
            s = (j <= 255) ? j : 510 - j;
            wait_nper(base + 2 + j);
            chk($sformatf("t5_b_j%0d", j), last_b[2], br_exp(s));
            chk($sformatf("t5_a_j%0d", j), last_a[2], clamp(br_exp(s), 64));
        end

        // ---- 6: reset with a staged write, then enable toggle ----
        mode = 2'd0;
        cfg_write(2'd3, 8'd7);
        chk("t6_red_high_pre", int'(red_b), 1);
        reset = 1'b1;
        step();
        chk("t6_rst_pwm_a", int'(pwm_a), 0);
        chk("t6_rst_pwm_b", int'(pwm_b), 0);
        chk("t6_rst_ready", int'(cfg_ready_a), 1);
        chk("t6_rst_ps", int'(period_start_a), 0);
        reset = 1'b0;
        cfg_write(2'd0, 8'd100);
        sync_ps();
        base = nper;
        wait_nper(base + 2);
        chk("t6_red_b", last_b[0], 100);
        chk("t6_green_b", last_b[1], 0);
        chk("t6_blue_b", last_b[2], 0);
        chk("t6_red_a", last_a[0], 64);

        repeat (4) step();
        chk("t6_red_high_pre_en", int'(red_b), 1);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t6_en_low_b_%0d", k), int'(pwm_b), 0);
            chk($sformatf("t6_en_low_a_%0d", k), int'(pwm_a), 0);
            chk($sformatf("t6_en_low_ps_%0d", k), int'(period_start_a), 0);
        end
        enable = 1'b1;
        begin
            int n = 0;
            do begin step(); n++; end while (!period_start_a && n < 1200);
            chk("t6_restart_len", n, 254);
        end
        base = nper;
        wait_nper(base + 2);
        chk("t6_after_en_red_b", last_b[0], 100);
        chk("t6_after_en_red_a", last_a[0], 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
